// File: rtl/mc_control_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_if
// Description : Fetch, load/store and datapath-select bundle of mc_control.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_control_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
);
    logic [31:0]         inst;
    logic                ifu_valid;
    logic                ifu_ready;
    logic                lsu_req;
    logic                lsu_wen;
    logic                lsu_ren;
    logic [XLEN/8-1:0]   lsu_mask;
    logic                lsu_done;
    logic [2:0]          imm_sel;
    logic [3:0]          alu_sel;
    logic                alu_a_sel;
    logic                alu_b_sel;
    logic                pc_sel;
    logic [1:0]          reg_w_sel;
    logic                reg_wen;
    logic                pc_wen;
    logic                halt;
    logic                illegal;
    logic [CNT_W-1:0]    instret;

    modport master (
        input  inst, ifu_valid, lsu_done,
        output ifu_ready, lsu_req, lsu_wen, lsu_ren, lsu_mask,
               imm_sel, alu_sel, alu_a_sel, alu_b_sel, pc_sel, reg_w_sel,
               reg_wen, pc_wen, halt, illegal, instret
    );

    modport slave (
        output inst, ifu_valid, lsu_done,
        input  ifu_ready, lsu_req, lsu_wen, lsu_ren, lsu_mask,
               imm_sel, alu_sel, alu_a_sel, alu_b_sel, pc_sel, reg_w_sel,
               reg_wen, pc_wen, halt, illegal, instret
    );
endinterface
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_control
// Description : Multi-cycle RV controller: FETCH/EXEC/MEM/WB/HALT sequencing,
//               instruction decode into datapath selects, retired counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic          clk,
    input  logic          rst,
    mc_control_if.master  bus
);
    localparam int         c_MASK_W   = XLEN / 8;
    localparam bit         c_HAS_64   = (XLEN == 64);

    localparam logic [2:0] c_S_FETCH  = 3'd0;
    localparam logic [2:0] c_S_EXEC   = 3'd1;
    localparam logic [2:0] c_S_MEM    = 3'd2;
    localparam logic [2:0] c_S_WB     = 3'd3;
    localparam logic [2:0] c_S_HALT   = 3'd4;

    // Select encodings shared with the datapath
    localparam logic [2:0] c_IMM_I    = 3'd0;
    localparam logic [2:0] c_IMM_S    = 3'd1;
    localparam logic [2:0] c_IMM_U    = 3'd3;
    localparam logic [2:0] c_IMM_UJ   = 3'd4;
    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_PASSB = 4'd15;
    localparam logic       c_A_RS1    = 1'b0;
    localparam logic       c_A_PC     = 1'b1;
    localparam logic       c_B_IMM    = 1'b1;
    localparam logic       c_PC_SNPC  = 1'b0;
    localparam logic       c_PC_ALU   = 1'b1;
    localparam logic [1:0] c_WB_ALU   = 2'd0;
    localparam logic [1:0] c_WB_PC    = 2'd1;
    localparam logic [1:0] c_WB_MEM   = 2'd2;

    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [31:0] c_EBREAK  = 32'h0010_0073;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [31:0]      r_ir;
    logic             r_halt;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_size_ok;
    logic       w_legal, w_is_load, w_is_store, w_is_ebreak, w_is_jump;
    logic [2:0] w_imm_sel;
    logic [3:0] w_alu_sel;
    logic       w_alu_a_sel;
    logic [7:0] w_mask8;
    logic       w_fire;

    logic w_ifu_ready, w_lsu_req, w_lsu_wen, w_lsu_ren, w_reg_wen, w_pc_wen;
    logic [c_MASK_W-1:0] w_lsu_mask;

    assign w_opcode  = r_ir[6:0];
    assign w_funct3  = r_ir[14:12];
    // Doubleword accesses exist only on the 64-bit datapath
    assign w_size_ok = !w_funct3[2] && (w_funct3[1:0] != 2'b11 || c_HAS_64);
    assign w_fire    = bus.ifu_valid && w_ifu_ready;

    always_comb begin
        w_legal     = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_ebreak = 1'b0;
        w_is_jump   = 1'b0;
        w_imm_sel   = c_IMM_I;
        w_alu_sel   = c_ALU_ADD;
        w_alu_a_sel = c_A_RS1;
        case (w_opcode)
            c_OP_IMM:   w_legal = (w_funct3 == 3'b000);
            c_OP_JALR: begin
                w_legal   = 1'b1;
                w_is_jump = 1'b1;
            end
            c_OP_JAL: begin
                w_legal     = 1'b1;
                w_is_jump   = 1'b1;
                w_imm_sel   = c_IMM_UJ;
                w_alu_a_sel = c_A_PC;
            end
            c_OP_AUIPC: begin
                w_legal     = 1'b1;
                w_imm_sel   = c_IMM_U;
                w_alu_a_sel = c_A_PC;
            end
            c_OP_LUI: begin
                w_legal   = 1'b1;
                w_imm_sel = c_IMM_U;
                w_alu_sel = c_ALU_PASSB;
            end
            c_OP_LOAD: begin
                w_legal   = w_size_ok;
                w_is_load = w_size_ok;
            end
            c_OP_STORE: begin
                w_legal    = w_size_ok;
                w_is_store = w_size_ok;
                w_imm_sel  = c_IMM_S;
            end
            default:    w_is_ebreak = (r_ir == c_EBREAK);
        endcase
    end

    always_comb begin
        case (w_funct3[1:0])
            2'b00:   w_mask8 = 8'h01;
            2'b01:   w_mask8 = 8'h03;
            2'b10:   w_mask8 = 8'h0F;
            default: w_mask8 = 8'hFF;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_FETCH;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_FETCH: if (bus.ifu_valid) w_next = c_S_EXEC;
            c_S_EXEC: begin
                if (w_is_load || w_is_store)     w_next = c_S_MEM;
                else if (w_is_ebreak || !w_legal) w_next = c_S_HALT;
                else                              w_next = c_S_WB;
            end
            c_S_MEM:   if (bus.lsu_done) w_next = c_S_WB;
            c_S_WB:    w_next = c_S_FETCH;
            c_S_HALT:  w_next = c_S_HALT;
            default:   w_next = c_S_FETCH;
        endcase
    end

    // Strobes are gated by rst so they drop in the reset cycle itself
    always_comb begin
        w_ifu_ready = 1'b0;
        w_lsu_req   = 1'b0;
        w_lsu_wen   = 1'b0;
        w_lsu_ren   = 1'b0;
        w_lsu_mask  = '0;
        w_reg_wen   = 1'b0;
        w_pc_wen    = 1'b0;
        case (r_state)
            c_S_FETCH: w_ifu_ready = !rst;
            c_S_MEM: begin
                w_lsu_req  = !rst;
                w_lsu_wen  = !rst && w_is_store;
                w_lsu_ren  = !rst && w_is_load;
                w_lsu_mask = w_mask8[c_MASK_W-1:0];
            end
            c_S_WB: begin
                w_pc_wen  = !rst;
                w_reg_wen = !rst && !w_is_store;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir      <= '0;
            r_halt    <= 1'b0;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            if (w_fire)
                r_ir <= bus.inst;
            if (r_state == c_S_EXEC && w_next == c_S_HALT) begin
                r_halt    <= 1'b1;
                r_illegal <= !w_is_ebreak;
            end
            if (r_state == c_S_WB)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign bus.ifu_ready = w_ifu_ready;
    assign bus.lsu_req   = w_lsu_req;
    assign bus.lsu_wen   = w_lsu_wen;
    assign bus.lsu_ren   = w_lsu_ren;
    assign bus.lsu_mask  = w_lsu_mask;
    assign bus.reg_wen   = w_reg_wen;
    assign bus.pc_wen    = w_pc_wen;
    assign bus.imm_sel   = w_imm_sel;
    assign bus.alu_sel   = w_alu_sel;
    assign bus.alu_a_sel = w_alu_a_sel;
    assign bus.alu_b_sel = c_B_IMM;
    assign bus.pc_sel    = w_is_jump ? c_PC_ALU : c_PC_SNPC;
    assign bus.reg_w_sel = w_is_jump ? c_WB_PC : (w_is_load ? c_WB_MEM : c_WB_ALU);
    assign bus.halt      = r_halt;
    assign bus.illegal   = r_illegal;
    assign bus.instret   = r_instret;
endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control
// Description : Randomized and directed bench for mc_control against a
//               transaction-level decode/latency model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_EBRK = 3, K_ILL = 4;

    typedef struct packed {
        logic [2:0] kind;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       a;
        logic       b;
        logic       pcs;
        logic [1:0] wsel;
        logic [7:0] mask;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_cnt;

    mc_control_if #(.XLEN(64), .CNT_W(64)) b64 ();
    mc_control_if #(.XLEN(32), .CNT_W(32)) b32 ();

    mc_control #(.XLEN(64), .CNT_W(64)) u_dut64 (.clk(clk), .rst(rst), .bus(b64.master));
    mc_control #(.XLEN(32), .CNT_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference decode: classify by instruction name and access size in bytes
    function automatic exp_t model(input logic [31:0] w, input int xlen);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        int          bytes;
        bit          size_ok;
        op      = w[6:0];
        f3      = w[14:12];
        bytes   = 1 << f3[1:0];
        size_ok = (f3[2] == 1'b0) && (bytes * 8 <= xlen);
        e = '{kind: 3'(K_ILL), imm: 3'd0, alu: 4'd0, a: 1'b0, b: 1'b1,
              pcs: 1'b0, wsel: 2'd0, mask: 8'h00};
        if (w == 32'h0010_0073) e.kind = 3'(K_EBRK);
        else if (op == 7'b0010011 && f3 == 3'd0) e.kind = 3'(K_ALU);
        else if (op == 7'b1100111) begin
            e.kind = 3'(K_ALU); e.pcs = 1'b1; e.wsel = 2'd1;
        end else if (op == 7'b1101111) begin
            e.kind = 3'(K_ALU); e.imm = 3'd4; e.a = 1'b1; e.pcs = 1'b1; e.wsel = 2'd1;
        end else if (op == 7'b0010111) begin
            e.kind = 3'(K_ALU); e.imm = 3'd3; e.a = 1'b1;
        end else if (op == 7'b0110111) begin
            e.kind = 3'(K_ALU); e.imm = 3'd3; e.alu = 4'd15;
        end else if (op == 7'b0000011 && size_ok) begin
            e.kind = 3'(K_LOAD); e.wsel = 2'd2; e.mask = 8'((1 << bytes) - 1);
        end else if (op == 7'b0100011 && size_ok) begin
            e.kind = 3'(K_STORE); e.imm = 3'd1; e.mask = 8'((1 << bytes) - 1);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sel(input string tag, input exp_t e);
        chk(tag, {b64.imm_sel, b64.alu_sel, b64.alu_a_sel, b64.alu_b_sel, b64.pc_sel, b64.reg_w_sel},
                 {e.imm, e.alu, e.a, e.b, e.pcs, e.wsel});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b64.ifu_valid = 1'b0; b64.lsu_done = 1'b0;
        b32.ifu_valid = 1'b0; b32.lsu_done = 1'b0;
        #1;
        chk("rst_ifu_ready", b64.ifu_ready, 0);
        chk("rst_strobes", {b64.lsu_req, b64.lsu_wen, b64.lsu_ren, b64.reg_wen, b64.pc_wen}, 0);
        step();
        chk("rst_instret", b64.instret, 0);
        chk("rst_flags", {b64.halt, b64.illegal}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", b64.ifu_ready, 1);
        exp_cnt = '0;
    endtask

    // Issue one instruction; lat = number of extra MEM cycles before lsu_done
    task automatic run_inst(input logic [31:0] w, input int lat, output bit halted);
        exp_t e;
        e = model(w, 64);
        halted = 1'b0;
        chk("fetch_ready", b64.ifu_ready, 1);
        b64.inst = w; b64.ifu_valid = 1'b1;
        step();
        b64.inst = $urandom; b64.ifu_valid = 1'($urandom_range(0, 1));
        b64.lsu_done = 1'($urandom_range(0, 1));
        chk("exec_strobes", {b64.ifu_ready, b64.lsu_req, b64.reg_wen, b64.pc_wen}, 0);
        if (e.kind == K_EBRK || e.kind == K_ILL) begin
            step();
            b64.ifu_valid = 1'b0; b64.lsu_done = 1'b0;
            chk("halt_flag", b64.halt, 1);
            chk("illegal_flag", b64.illegal, (e.kind == K_ILL) ? 1 : 0);
            chk("halt_instret", b64.instret, exp_cnt);
            chk("halt_ready", b64.ifu_ready, 0);
            halted = 1'b1;
            return;
        end
        chk_sel("exec_sel", e);
        step();
        if (e.kind == K_LOAD || e.kind == K_STORE) begin
            for (int i = 0; i <= lat; i++) begin
                chk("mem_req", b64.lsu_req, 1);
                chk("mem_wen_ren", {b64.lsu_wen, b64.lsu_ren},
                    (e.kind == K_STORE) ? 2'b10 : 2'b01);
                chk("mem_mask", b64.lsu_mask, e.mask);
                chk_sel("mem_sel", e);
                b64.lsu_done = (i == lat);
                b64.ifu_valid = 1'($urandom_range(0, 1));
                step();
            end
        end
        b64.lsu_done = 1'b0; b64.ifu_valid = 1'b0;
        chk("wb_pc_wen", b64.pc_wen, 1);
        chk("wb_reg_wen", b64.reg_wen, (e.kind == K_STORE) ? 0 : 1);
        chk("wb_lsu_idle", {b64.lsu_req, b64.lsu_mask}, 0);
        chk_sel("wb_sel", e);
        exp_cnt = exp_cnt + 64'd1;
        step();
        chk("fetch_instret", b64.instret, exp_cnt);
        chk("fetch_back", {b64.ifu_ready, b64.pc_wen, b64.reg_wen}, 3'b100);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: return {r[31:20], r[19:15], 3'b000, r[11:7], 7'b0010011};
            1: return {r[31:20], r[19:15], 3'b000, r[11:7], 7'b1100111};
            2: return {r[31:12], r[11:7], 7'b1101111};
            3: return {r[31:12], r[11:7], 7'b0010111};
            4: return {r[31:12], r[11:7], 7'b0110111};
            5: return {r[31:15], 1'b0, r[13:12], r[11:7], 7'b0000011};
            6: return {r[31:15], 1'b0, r[13:12], r[11:7], 7'b0100011};
            7: return {r[31:15], r[14:12], r[11:7], 7'b0010011};
            8: return r;
            default: return {r[31:7], r[0] ? 7'b0000011 : 7'b0100011};
        endcase
    endfunction

    initial begin
        bit halted;
        rst = 1'b1;
        b64.inst = '0; b64.ifu_valid = 1'b0; b64.lsu_done = 1'b0;
        b32.inst = '0; b32.ifu_valid = 1'b0; b32.lsu_done = 1'b0;
        exp_cnt = '0;
        step();
        do_reset();

        // addi x1,x0,5
        run_inst(32'h0050_0093, 0, halted);
        // sd with lsu_done in the third MEM cycle
        run_inst(32'h0011_3023, 2, halted);
        // jal x1,+8
        run_inst(32'h0080_00EF, 0, halted);
        // lui, lb with zero-latency done
        run_inst(32'h1234_50B7, 0, halted);
        run_inst(32'h0001_0083, 0, halted);

        // ebreak, then fetch attempts must be ignored
        run_inst(32'h0010_0073, 0, halted);
        b64.ifu_valid = 1'b1; b64.inst = 32'h0050_0093;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt_absorb", {b64.halt, b64.illegal, b64.ifu_ready, b64.pc_wen, b64.reg_wen}, 5'b10000);
            chk("halt_instret_hold", b64.instret, exp_cnt);
        end
        b64.ifu_valid = 1'b0;
        do_reset();

        run_inst(32'hFFFF_FFFF, 0, halted);
        do_reset();

        for (int n = 0; n < 60; n++) begin
            run_inst(rand_inst(), int'($urandom_range(0, 4)), halted);
            if (halted) do_reset();
        end

        // Reset while waiting in MEM: access dropped, nothing committed
        run_inst(32'h0050_0093, 0, halted);
        b64.inst = 32'h0001_3083; b64.ifu_valid = 1'b1;
        step();
        b64.ifu_valid = 1'b0;
        step();
        chk("mem_wait_req", b64.lsu_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_mem_req_same", b64.lsu_req, 0);
        step();
        chk("rst_mem_req_next", b64.lsu_req, 0);
        chk("rst_mem_instret", b64.instret, 0);
        chk("rst_mem_nocommit", {b64.pc_wen, b64.reg_wen}, 0);
        rst = 1'b0;
        #1;
        chk("rst_mem_fetch", b64.ifu_ready, 1);
        exp_cnt = '0;

        // 32-bit datapath: lw legal with 4-byte mask, ld illegal
        b32.inst = 32'h0001_2083; b32.ifu_valid = 1'b1;
        step();
        b32.ifu_valid = 1'b0;
        step();
        chk("x32_lw_req", {b32.lsu_req, b32.lsu_ren, b32.lsu_wen}, 3'b110);
        chk("x32_lw_mask", b32.lsu_mask, 4'hF);
        b32.lsu_done = 1'b1;
        step();
        b32.lsu_done = 1'b0;
        chk("x32_lw_wb", {b32.pc_wen, b32.reg_wen, b32.reg_w_sel}, 4'b1110);
        step();
        chk("x32_lw_instret", b32.instret, 1);
        b32.inst = 32'h0001_3083; b32.ifu_valid = 1'b1;
        step();
        b32.ifu_valid = 1'b0;
        step();
        chk("x32_ld_illegal", {b32.halt, b32.illegal}, 2'b11);
        chk("x32_ld_instret", b32.instret, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
